window_gen_3x3: RTL
===================

Name: window_gen_3x3

Overview:
- Streaming 3x3 neighbourhood generator for the noise-reduction datapath.
- Accepts a raster pixel stream and produces the nine window taps c1..c9 with a valid strobe.
- The taps feed add_pipeline_16bit and the weighting stages; this block is the producer end of that c1..c9 interface.
- Uses two internal line buffers and a 3x3 register window.

Parameters:
- DATA_W, 16, pixel width in bits; also the width of each tap c1..c9.
- IMG_W, 640, pixels per line, minimum 3.
- IMG_H, 480, lines per frame, minimum 3.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- sof  in  1  start of frame; qualified by pix_valid and marks the pixel at (row 0, col 0).
- pix_valid  in  1  pixel-in strobe; no backpressure.
- pix_in  in  DATA_W  pixel data.
- c1..c9  out  DATA_W each  window taps in raster order: c1 = (r-2, x-2), c3 = (r-2, x), c5 = centre (r-1, x-1), c9 = (r, x) = newest pixel.
- win_valid  out  1  window taps valid; single-cycle pulse per window.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, counters 0. Line-buffer contents are don't-care because no window reads them before they are written.
- FSM states:
  - IDLE: wait for sof & pix_valid.
  - ACTIVE: accept pixels.
  - DONE: ignore pixels until the next sof.
- Transitions:
  - IDLE -> ACTIVE on sof & pix_valid. That pixel is accepted as (0,0).
  - ACTIVE -> DONE when pixel (IMG_H-1, IMG_W-1) is accepted; frame_done pulses on the next cycle.
  - DONE -> ACTIVE on sof & pix_valid.
- Accepted pixel: pix_valid=1 in ACTIVE, or the sof pixel that starts a frame.
- In IDLE/DONE, pix_valid without sof is ignored and has no state change.
- Counters:
  - col runs 0..IMG_W-1 and wraps to 0.
  - row increments when col wraps.
  - Both advance only on accepted pixels.
- sof during ACTIVE aborts the current frame:
  - counters restart with this pixel as (0,0);
  - no frame_done is issued for the aborted frame;
  - line-buffer data from the aborted frame must never appear in a window of the new frame.
- Per accepted pixel:
  - The window shifts left one column.
  - The new right column is {linebuf1[col], linebuf0[col], pix_in}, top to bottom.
  - linebuf1[col] is then written with the old linebuf0[col], and linebuf0[col] with pix_in.
- Validity:
  - win_valid = 1 on the cycle after an accepted pixel with row>=2 and col>=2, else 0.
  - Latency is one clock from pixel to window.
  - No windows straddle a line wrap (col 0/1 suppressed). No border padding.
- Output holding: taps hold their value between accepted pixels. Gaps in pix_valid insert bubbles only; the data sequence is unchanged.
- Window count: (IMG_W-2)*(IMG_H-2) win_valid pulses per complete frame.
- Reset mid-frame: immediate return to IDLE with all outputs 0. The next frame needs a new sof.

Optional Feature:
- Macro: WIN_COORD_EN.
- When defined, the block adds two outputs, registered and aligned with win_valid, both 0 at reset and held between windows:
  - win_x, width clog2(IMG_W): column of the centre tap c5, equal to col-1.
  - win_y, width clog2(IMG_H): row of the centre tap c5, equal to row-1.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- IMG_W=8, IMG_H=4; pixel value = 8*row + col; pix_valid continuous, sof on the first pixel:
  - first win_valid one clock after pixel (2,2), with c1..c9 = 0,1,2,8,9,10,16,17,18;
  - exactly 12 win_valid pulses;
  - frame_done pulses once, one clock after pixel (3,7).
- Same frame with pix_valid toggled 1,0,0,1,... -> identical tap sequence and pulse count; taps stable during gaps.
- pix_valid=1 with pixels 0xFFFF for 5 cycles before any sof -> no win_valid, no frame_done; the subsequent frame matches test 1 exactly.
- sof reasserted at (2,4) mid-frame -> no frame_done for the aborted frame; new frame output matches test 1 with no stale data.
- rst_n low for 1 cycle at (3,3) -> all outputs 0 during and after reset; pixels ignored until sof; the next frame matches test 1.
- With WIN_COORD_EN: on the first window, win_x=1, win_y=1; on the last window (12th), win_x=6, win_y=2.

Source files
------------

// File: rtl/window_gen_3x3.sv
// ---------------------------------------------------------------------------
// window_gen_3x3
// Streaming 3x3 neighbourhood generator. It accepts a raster pixel stream and
// presents the nine window taps c1..c9 in raster order. c1 is the oldest
// (top-left) tap and c9 is the newest pixel. The window is built from two line
// buffers and a 3x3 register window.
//
// Optional feature (macro WIN_COORD_EN): this adds outputs win_x and win_y. They
// give the coordinates of the centre tap c5. They are registered and aligned
// with win_valid.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   sof        in   start of frame, qualified by pix_valid; marks pixel (0,0)
//   pix_valid  in   pixel-in strobe (no backpressure)
//   pix_in     in   pixel data, DATA_W bits
//   c1..c9     out  window taps, DATA_W bits each
//   win_valid  out  one-cycle pulse per complete 3x3 window
//   frame_done out  one-cycle pulse after the last pixel of a frame
//   win_x      out  (WIN_COORD_EN only) column of c5, $clog2(IMG_W) bits
//   win_y      out  (WIN_COORD_EN only) row of c5, $clog2(IMG_H) bits
// ---------------------------------------------------------------------------
module window_gen_3x3 #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sof,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_in,
    output logic [DATA_W-1:0] c1,
    output logic [DATA_W-1:0] c2,
    output logic [DATA_W-1:0] c3,
    output logic [DATA_W-1:0] c4,
    output logic [DATA_W-1:0] c5,
    output logic [DATA_W-1:0] c6,
    output logic [DATA_W-1:0] c7,
    output logic [DATA_W-1:0] c8,
    output logic [DATA_W-1:0] c9,
`ifdef WIN_COORD_EN
    output logic [$clog2(IMG_W)-1:0] win_x,
    output logic [$clog2(IMG_H)-1:0] win_y,
`endif
    output logic              win_valid,
    output logic              frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [CW-1:0]     col_r;
    logic [RW-1:0]     row_r;
    logic [CW-1:0]     cur_col_s;
    logic [RW-1:0]     cur_row_s;
    logic              accept_s;
    logic              last_col_s;
    logic              last_row_s;
    logic              win_hit_s;
    logic [DATA_W-1:0] lb0_r [IMG_W];
    logic [DATA_W-1:0] lb1_r [IMG_W];
    logic [DATA_W-1:0] lb0_rd_s;
    logic [DATA_W-1:0] lb1_rd_s;
    logic [DATA_W-1:0] win_r [9];
    logic              win_valid_r;
    logic              frame_done_r;

    // Decide whether this pixel is accepted, and find its coordinate.
    // A sof pixel is always (0,0). This lets an abort restart cleanly.
    always_comb begin
        accept_s  = 1'b0;
        cur_col_s = col_r;
        cur_row_s = row_r;
        if (pix_valid && (sof || (state_r == ACTIVE))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (sof) begin
            cur_col_s = '0;
            cur_row_s = '0;
        end else begin
            cur_col_s = col_r;
            cur_row_s = row_r;
        end
        last_col_s = (cur_col_s == CW'(IMG_W - 1));
        last_row_s = (cur_row_s == RW'(IMG_H - 1));
        win_hit_s  = accept_s && (cur_row_s >= RW'(2)) && (cur_col_s >= CW'(2));
        lb0_rd_s   = lb0_r[cur_col_s];
        lb1_rd_s   = lb1_r[cur_col_s];
    end

    // Frame FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (pix_valid && sof) begin
                    state_nxt_s = ACTIVE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ACTIVE: begin
                if (accept_s && last_col_s && last_row_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ACTIVE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, raster counters, window registers and output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            col_r        <= '0;
            row_r        <= '0;
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_r[i] <= '0;
            end
        end else begin
            state_r      <= state_nxt_s;
            win_valid_r  <= win_hit_s;
            frame_done_r <= accept_s && last_col_s && last_row_s;
            if (accept_s) begin
                if (last_col_s) begin
                    col_r <= '0;
                    row_r <= last_row_s ? '0 : cur_row_s + RW'(1);
                end else begin
                    col_r <= cur_col_s + CW'(1);
                    row_r <= cur_row_s;
                end
                // Shift left one column; the new right column is the oldest to newest line.
                win_r[0] <= win_r[1];
                win_r[1] <= win_r[2];
                win_r[2] <= lb1_rd_s;
                win_r[3] <= win_r[4];
                win_r[4] <= win_r[5];
                win_r[5] <= lb0_rd_s;
                win_r[6] <= win_r[7];
                win_r[7] <= win_r[8];
                win_r[8] <= pix_in;
            end else begin
                col_r <= col_r;
                row_r <= row_r;
            end
        end
    end

    // Line buffers have no reset. No valid window reads an entry
    // before the current frame has written it. A sof restart refills both lines first.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb1_r[cur_col_s] <= lb0_rd_s;
            lb0_r[cur_col_s] <= pix_in;
        end
    end

`ifdef WIN_COORD_EN
    logic [CW-1:0] win_x_r;
    logic [RW-1:0] win_y_r;

    // Centre-tap coordinates. They update only with a window and hold in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_x_r <= '0;
            win_y_r <= '0;
        end else if (win_hit_s) begin
            win_x_r <= cur_col_s - CW'(1);
            win_y_r <= cur_row_s - RW'(1);
        end else begin
            win_x_r <= win_x_r;
            win_y_r <= win_y_r;
        end
    end

    assign win_x = win_x_r;
    assign win_y = win_y_r;
`endif

    assign c1         = win_r[0];
    assign c2         = win_r[1];
    assign c3         = win_r[2];
    assign c4         = win_r[3];
    assign c5         = win_r[4];
    assign c6         = win_r[5];
    assign c7         = win_r[6];
    assign c8         = win_r[7];
    assign c9         = win_r[8];
    assign win_valid  = win_valid_r;
    assign frame_done = frame_done_r;

endmodule
